// File: rtl/seq4_controller.sv
// seq4_controller: four-state sequencer with per-state programmable dwell.
// Each state Sn is held for dwell[n]+1 cycles of run=1, then the sequence
// advances forward (S0->S1->S2->S3->S0) or in reverse (S0->S3->S2->S1->S0)
// depending on dir at the moment of the transition. The block has no
// valid/ready handshake: cfg_we is a plain write strobe accepted on every
// edge, and step/wrap are unqualified one-cycle pulses.
module seq4_controller #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             dir,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [1:0]       state,
  output logic [3:0]       state_oh,
  output logic             step,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t           state_q, state_d;
  state_t           succ;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] dwell_q [4];
  logic [CNT_W-1:0] dwell_cur;
  logic             dwell_done;

  // Dwell of the current state; a write on this edge is only seen next cycle.
  always_comb begin
    dwell_cur  = dwell_q[state_q];
    // >= rather than == so lowering dwell below cnt mid-state still exits.
    dwell_done = (cnt_q >= dwell_cur);
  end

  // Successor state; dir only matters on the edge that actually transitions.
  always_comb begin
    succ = S0;
    unique case (state_q)
      S0: succ = dir ? S3 : S1;
      S1: succ = dir ? S0 : S2;
      S2: succ = dir ? S1 : S3;
      S3: succ = dir ? S2 : S0;
    endcase
  end

  // Next-state logic: clear beats counting/transition; pulses default low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear) begin
      state_d = S0;
      cnt_d   = '0;
    end else if (run) begin
      if (dwell_done) begin
        state_d = succ;
        cnt_d   = '0;
        step_d  = 1'b1;
        wrap_d  = dir ? (state_q == S0) : (state_q == S3);
      end else begin
        // cnt < dwell here, so the increment can never overflow.
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  // Dwell register file; writes proceed even while clear is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) dwell_q[i] <= '0;
    end else if (cfg_we) begin
      dwell_q[cfg_addr] <= cfg_data;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    state_oh          = 4'b0000;
    state_oh[state_q] = 1'b1;
    state             = state_q;
    step              = step_q;
    wrap              = wrap_q;
  end

endmodule
